alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Sequential initiator for the combinational 4-bit-control N-bit ALU.
- Accepts operation commands (A, B, op) over a valid/ready interface into a small command FIFO.
- Drives them one at a time onto registered ALU operand/control outputs, captures ALU_Result/zero one cycle later, and returns them over a valid/ready response interface.
- Replaces hand-timed testbench stimulus as the ALU's driver in system and bench contexts.

Parameters:
N, 32, operand/result width.
DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full and rst low.
cmd_a  in  N  operand A.
cmd_b  in  N  operand B.
cmd_op  in  4  ALU control code.
alu_a  out  N  registered operand A to ALU.
alu_b  out  N  registered operand B to ALU.
alu_control  out  4  registered control to ALU.
alu_result  in  N  combinational ALU result.
alu_zero  in  1  ALU zero flag.
rsp_valid  out  1  response held.
rsp_ready  in  1  response consumed.
rsp_result  out  N  captured result.
rsp_zero  out  1  captured zero flag.
rsp_op  out  4  op code of this response.
rsp_illegal  out  1  op > 4'b1010.
busy  out  1  high when state is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset: FIFO flushed (empty); state IDLE. alu_a, alu_b, alu_control, rsp_valid, rsp_result, rsp_zero, rsp_op and rsp_illegal are all 0. cmd_ready=0 while rst is high. Any in-flight command or pending response is discarded, with no partial response.
- Push: on cmd_valid && cmd_ready at an edge, the command is written to the FIFO tail. cmd_ready = !full, so no push occurs when full, even if a pop happens on the same edge. Push and pop on the same edge are allowed when not full; count is then unchanged.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop at the edge, load alu_a/alu_b/alu_control from the head, and go to ISSUE. Otherwise stay; the ALU outputs hold their last values.
  - ISSUE: one full cycle for the ALU to settle. At the next edge, capture alu_result, alu_zero and the op into the rsp_* registers, set rsp_valid=1, and go to RESP.
  - RESP: rsp_* are held stable while rsp_valid && !rsp_ready. On an edge with rsp_ready:
    - FIFO non-empty: clear rsp_valid, pop and load the next command, go to ISSUE.
    - Otherwise: clear rsp_valid and go to IDLE.
- Latency: push at edge E0, ALU load at E1, rsp_valid high after E2 (2 cycles). Peak throughput is 1 response per 2 cycles.
- Illegal op (cmd_op > 4'b1010): still follows the IDLE/ISSUE/RESP flow and ordering.
  - alu_a, alu_b and alu_control are NOT updated; they keep their previous values.
  - Response: rsp_illegal=1, rsp_result=0, rsp_zero=0, rsp_op = the offending code.
- Legal responses have rsp_illegal=0.
- Ordering: responses return strictly in command order; no command is dropped or duplicated.
- FIFO pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH. full when the MSBs differ and the index bits are equal; empty when the pointers are equal.

Optional Feature:
Macro ALU_ISSUER_STATS_EN.
- Defined: adds output rsp_count (16 bits) and output illegal_count (8 bits).
  - rsp_count increments on each rsp_valid && rsp_ready handshake.
  - illegal_count increments when that handshake carries rsp_illegal=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
Bench stub ALU: alu_result = alu_a ^ alu_b; alu_zero = (alu_result == 0).
- Single command A=15, B=12, op=4'b0000, rsp_ready=1 -> rsp_valid rises 2 cycles after the push edge; rsp_result=3, rsp_zero=0, rsp_op=0, rsp_illegal=0.
- Zero case A=230005, B=230005, op=4'b0010 -> rsp_result=0, rsp_zero=1.
- Backpressure: push 5 commands with rsp_ready=0 and DEPTH=4 -> after the first pop, 4 more fit; the 6th push sees cmd_ready=0. rsp_* remain stable. Then rsp_ready=1 -> 5 responses in order, 2 cycles apart.
- Illegal op 4'b1100 between legal ops (44241422, 4324222, 4'b0100) -> rsp_illegal=1, rsp_result=0. alu_control stays 4'b0100 from the prior command. The next legal response is correct.
- Reset asserted in ISSUE with 2 commands queued -> outputs go to 0 immediately (asynchronously); after release no response appears, busy=0, cmd_ready=1.
- With ALU_ISSUER_STATS_EN: 3 legal plus 1 illegal command completed -> rsp_count=4, illegal_count=1.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus IDLE/ISSUE/RESP sequencer that drives a combinational ALU and returns its results in order.
// Optional statistics counters (rsp_count, illegal_count) are enabled by defining ALU_ISSUER_STATS_EN.
module alu_cmd_issuer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [3:0]   cmd_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [3:0]   rsp_op,
    output logic         rsp_illegal,
    output logic         busy,
    output logic [1:0]   dbg_state_o
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]  rsp_count,
    output logic [7:0]   illegal_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid is high and ready is low.

    logic [N-1:0] mem_a  [DEPTH];
    logic [N-1:0] mem_b  [DEPTH];
    logic [3:0]   mem_op [DEPTH];

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         full, empty, push, pop;

    state_t       state_q, state_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_ctl_q, alu_ctl_d;
    logic [3:0]   op_q, op_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic [3:0]   rsp_op_q, rsp_op_d;
    logic         rsp_illegal_q, rsp_illegal_d;

    logic [N-1:0] head_a, head_b;
    logic [3:0]   head_op;
    logic         inflight_illegal;

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign cmd_ready = !full && !rst;
    assign push  = cmd_valid && cmd_ready;

    assign head_a  = mem_a[rd_ptr_q[PW-1:0]];
    assign head_b  = mem_b[rd_ptr_q[PW-1:0]];
    assign head_op = mem_op[rd_ptr_q[PW-1:0]];
    assign inflight_illegal = (op_q > OP_MAX);

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q[PW-1:0]]  <= cmd_a;
            mem_b[wr_ptr_q[PW-1:0]]  <= cmd_b;
            mem_op[wr_ptr_q[PW-1:0]] <= cmd_op;
        end
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctl_d     = alu_ctl_q;
        op_d          = op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_op_d      = rsp_op_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_valid_d   = 1'b1;
                rsp_op_d      = op_q;
                rsp_illegal_d = inflight_illegal;
                rsp_result_d  = inflight_illegal ? '0 : alu_result;
                rsp_zero_d    = inflight_illegal ? 1'b0 : alu_zero;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Illegal codes travel through the pipeline but leave the ALU inputs untouched.
        if (pop) begin
            op_d = head_op;
            if (head_op <= OP_MAX) begin
                alu_a_d   = head_a;
                alu_b_d   = head_b;
                alu_ctl_d = head_op;
            end
        end
    end

    assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctl_q     <= '0;
            op_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_op_q      <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctl_q     <= alu_ctl_d;
            op_q          <= op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_op_q      <= rsp_op_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_illegal = rsp_illegal_q;
    assign busy        = (state_q != IDLE) || !empty;
    assign dbg_state_o = state_q;

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] rsp_count_q, rsp_count_d;
    logic [7:0]  illegal_count_q, illegal_count_d;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_comb begin
        rsp_count_d     = rsp_count_q;
        illegal_count_d = illegal_count_q;
        if (rsp_fire && (rsp_count_q != 16'hFFFF)) begin
            rsp_count_d = rsp_count_q + 16'd1;
        end
        if (rsp_fire && rsp_illegal_q && (illegal_count_q != 8'hFF)) begin
            illegal_count_d = illegal_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_count_q     <= '0;
            illegal_count_q <= '0;
        end else begin
            rsp_count_q     <= rsp_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign rsp_count     = rsp_count_q;
    assign illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer using an XOR stub ALU; expected values are hand-derived.
// Define ALU_ISSUER_STATS_EN to also exercise the statistics counters.
module tb_alu_cmd_issuer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  rsp_op;
    logic        rsp_illegal;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] rsp_count;
    logic [7:0]  illegal_count;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    alu_cmd_issuer #(.N(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_op      (rsp_op),
        .rsp_illegal (rsp_illegal),
        .busy        (busy),
        .dbg_state_o (dbg_state)
`ifdef ALU_ISSUER_STATS_EN
        ,
        .rsp_count     (rsp_count),
        .illegal_count (illegal_count)
`endif
    );

    // Stub ALU
    assign alu_result = alu_a ^ alu_b;
    assign alu_zero   = (alu_result == 32'd0);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One command end to end with rsp_ready held high; called at a falling edge.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] ec,
                           input logic [31:0] eres, input logic ezero, input logic eill);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        check_eq("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_eq("lat1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("lat1_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("alu_a", alu_a, ea);
        check_eq("alu_b", alu_b, eb);
        check_eq("alu_control", {28'd0, alu_control}, {28'd0, ec});
        check_eq("lat2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rsp_result", rsp_result, eres);
        check_eq("rsp_zero", {31'd0, rsp_zero}, {31'd0, ezero});
        check_eq("rsp_op", {28'd0, rsp_op}, {28'd0, op});
        check_eq("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, eill});
        tick();
        check_eq("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("post_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        check_eq("push_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a_v;
        logic [31:0] b_v;
        logic [31:0] held;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_control", {28'd0, alu_control}, 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic, zero flag, illegal sandwiched between legal ops
        run_one(32'd15, 32'd12, 4'b0000, 32'd15, 32'd12, 4'b0000, 32'd3, 1'b0, 1'b0);
        run_one(32'd230005, 32'd230005, 4'b0010, 32'd230005, 32'd230005, 4'b0010, 32'd0, 1'b1, 1'b0);
        run_one(32'd44241422, 32'd4324222, 4'b0100, 32'd44241422, 32'd4324222, 4'b0100,
                32'd44241422 ^ 32'd4324222, 1'b0, 1'b0);
        run_one(32'h1234, 32'h5678, 4'b1100, 32'd44241422, 32'd4324222, 4'b0100, 32'd0, 1'b0, 1'b1);
        run_one(32'h55, 32'h0F, 4'b1001, 32'h55, 32'h0F, 4'b1001, 32'h5A, 1'b0, 1'b0);

        // Backpressure: five pushes fit (one popped), sixth sees a full FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_v = 32'hA000_0000 + 32'(i * 17);
            b_v = 32'(i * 3 + 1);
            push_cmd(a_v, b_v, 4'(i));
            exp_q.push_back(a_v ^ b_v);
        end
        cmd_a     = 32'hDEAD;
        cmd_b     = 32'hBEEF;
        cmd_op    = 4'b0001;
        cmd_valid = 1'b1;
        check_eq("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        held = exp_q[0];
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_hold_result", rsp_result, held);
            check_eq("bp_hold_op", {28'd0, rsp_op}, 32'd0);
            check_eq("bp_still_full", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("drain_result", rsp_result, exp_q.pop_front());
            check_eq("drain_op", {28'd0, rsp_op}, 32'(i));
            tick();
            check_eq("drain_gap", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        check_eq("drain_busy", {31'd0, busy}, 32'd0);

        // Reset while in ISSUE with two commands still queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(32'h0F0F_0000 + 32'(i), 32'h0000_1111, 4'b0011);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("pre_rst_state", {30'd0, dbg_state}, 32'd1);
        check_eq("pre_rst_result", rsp_result, 32'h0F0F_1111);
        rst = 1'b1;
        #1;
        check_eq("arst_alu_a", alu_a, 32'd0);
        check_eq("arst_alu_b", alu_b, 32'd0);
        check_eq("arst_alu_control", {28'd0, alu_control}, 32'd0);
        check_eq("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("arst_rsp_result", rsp_result, 32'd0);
        check_eq("arst_rsp_op", {28'd0, rsp_op}, 32'd0);
        check_eq("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        check_eq("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef ALU_ISSUER_STATS_EN
        check_eq("stats_rst_rsp", {16'd0, rsp_count}, 32'd0);
        check_eq("stats_rst_ill", {24'd0, illegal_count}, 32'd0);
        run_one(32'd1, 32'd2, 4'b0000, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0);
        run_one(32'd7, 32'd7, 4'b0001, 32'd7, 32'd7, 4'b0001, 32'd0, 1'b1, 1'b0);
        run_one(32'd9, 32'd9, 4'b1111, 32'd7, 32'd7, 4'b0001, 32'd0, 1'b0, 1'b1);
        run_one(32'd8, 32'd1, 4'b0110, 32'd8, 32'd1, 4'b0110, 32'd9, 1'b0, 1'b0);
        check_eq("stats_rsp_count", {16'd0, rsp_count}, 32'd4);
        check_eq("stats_illegal_count", {24'd0, illegal_count}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
